// File: rtl/paint_brush_ctrl.sv
// paint_brush_ctrl: expands one brush command (MOVE/PAINT/ERASE/CLEAR) into a
// per-pixel write sequence for the dual-bank paint frame memory and its backup.
// Latency: first write cycle follows the accepting edge; all outputs registered.
// Backpressure: i_cmd_valid is only taken while o_cmd_ready (IDLE); hold otherwise.
// Ports: i_clk/i_rst (sync, active-high); i_cmd_* command with valid/ready;
//   o_done one-cycle completion pulse; o_addr_write/o_wr0/o_wr1/o_wdata/
//   o_paint_permanent drive the write port; i_b_rdata0/1 backup read data.
module paint_brush_ctrl #(
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [5:0]  i_cmd_x,
  input  logic [5:0]  i_cmd_y,
  input  logic [1:0]  i_cmd_size,
  input  logic [11:0] i_cmd_color,
  output logic        o_done,
  output logic [11:0] o_addr_write,
  output logic        o_wr0,
  output logic        o_wr1,
  output logic [11:0] o_wdata,
  output logic        o_paint_permanent,
  input  logic [11:0] i_b_rdata0,
  input  logic [11:0] i_b_rdata1
);

  localparam logic [1:0] OP_MOVE  = 2'd0;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_RESTORE_RD, S_RESTORE_WR, S_DRAW, S_FILL
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_op, r_size, r_dx, r_dy, r_cur_size;
  logic [5:0]  r_x, r_y, r_cur_x, r_cur_y;
  logic [11:0] r_color;
  logic [10:0] r_fill;
  logic        r_cur_valid;

  logic        r_cmd_ready, r_done, r_wr0, r_wr1, r_perm;
  logic [11:0] r_addr, r_wdata;

  logic        w_accept;
  logic [1:0]  w_lim, w_adv_dx, w_adv_dy, w_dx_nxt, w_dy_nxt;
  logic        w_last;
  logic [10:0] w_fill_nxt;
  logic [1:0]  w_op_nxt, w_size_nxt;
  logic [5:0]  w_x_nxt, w_y_nxt, w_ox, w_oy;
  logic [11:0] w_color_nxt;
  logic [6:0]  w_px, w_py;
  logic        w_clip;
  logic [11:0] w_pix_addr;

  logic        w_ready_nxt, w_done_nxt, w_wr0_nxt, w_wr1_nxt, w_perm_nxt;
  logic [11:0] w_addr_nxt, w_wdata_nxt;

  assign w_accept = i_cmd_valid & r_cmd_ready;

  // Command fields as they will be after this edge, so the first pixel's
  // outputs can be registered on the accepting edge itself.
  assign w_op_nxt    = w_accept ? i_cmd_op    : r_op;
  assign w_x_nxt     = w_accept ? i_cmd_x     : r_x;
  assign w_y_nxt     = w_accept ? i_cmd_y     : r_y;
  assign w_size_nxt  = w_accept ? i_cmd_size  : r_size;
  assign w_color_nxt = w_accept ? i_cmd_color : r_color;

  // Scan step: restore walks the old cursor square, draw walks the new one.
  assign w_lim    = (r_state == S_DRAW) ? r_size : r_cur_size;
  assign w_last   = (r_dx == w_lim) && (r_dy == w_lim);
  assign w_adv_dx = (r_dx == w_lim) ? 2'd0 : r_dx + 2'd1;
  assign w_adv_dy = (r_dx == w_lim) ? r_dy + 2'd1 : r_dy;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_dx_nxt    = r_dx;
    w_dy_nxt    = r_dy;
    w_fill_nxt  = r_fill;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_dx_nxt   = 2'd0;
        w_dy_nxt   = 2'd0;
        w_fill_nxt = 11'd0;
        if (i_cmd_op == OP_CLEAR)
          w_state_nxt = S_FILL;
        else if (i_cmd_op == OP_MOVE && r_cur_valid)
          w_state_nxt = S_RESTORE_RD;
        else
          w_state_nxt = S_DRAW;
      end
      S_RESTORE_RD: w_state_nxt = S_RESTORE_WR;
      S_RESTORE_WR: begin
        if (w_last) begin
          w_state_nxt = S_DRAW;
          w_dx_nxt    = 2'd0;
          w_dy_nxt    = 2'd0;
        end else begin
          w_state_nxt = S_RESTORE_RD;
          w_dx_nxt    = w_adv_dx;
          w_dy_nxt    = w_adv_dy;
        end
      end
      S_DRAW: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_dx_nxt = w_adv_dx;
          w_dy_nxt = w_adv_dy;
        end
      end
      S_FILL: begin
        if (&r_fill) w_state_nxt = S_IDLE;
        else         w_fill_nxt  = r_fill + 11'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pixel of the upcoming cycle; sums are 7 bits so bit 6 flags clipping.
  assign w_ox       = (w_state_nxt == S_DRAW) ? w_x_nxt : r_cur_x;
  assign w_oy       = (w_state_nxt == S_DRAW) ? w_y_nxt : r_cur_y;
  assign w_px       = {1'b0, w_ox} + {5'd0, w_dx_nxt};
  assign w_py       = {1'b0, w_oy} + {5'd0, w_dy_nxt};
  assign w_clip     = w_px[6] | w_py[6];
  assign w_pix_addr = {1'b0, w_py[4:0], w_px[5:0]};

  // Output logic, evaluated for the upcoming state and then registered
  always_comb begin
    w_ready_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_addr_nxt  = 12'd0;
    w_wr0_nxt   = 1'b0;
    w_wr1_nxt   = 1'b0;
    w_wdata_nxt = 12'd0;
    w_perm_nxt  = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        w_done_nxt  = (r_state != S_IDLE);
      end
      S_RESTORE_RD: begin
        w_addr_nxt  = w_pix_addr;
        w_wdata_nxt = r_wdata;
      end
      S_RESTORE_WR: begin
        // Backup data of the pixel presented during RESTORE_RD.
        w_addr_nxt  = w_pix_addr;
        w_wr0_nxt   = ~w_clip & ~w_py[5];
        w_wr1_nxt   = ~w_clip &  w_py[5];
        w_wdata_nxt = w_py[5] ? i_b_rdata1 : i_b_rdata0;
      end
      S_DRAW: begin
        w_addr_nxt  = w_pix_addr;
        w_wr0_nxt   = ~w_clip & ~w_py[5];
        w_wr1_nxt   = ~w_clip &  w_py[5];
        w_wdata_nxt = (w_op_nxt == OP_ERASE) ? BG_COLOR : w_color_nxt;
        w_perm_nxt  = (w_op_nxt != OP_MOVE);
      end
      S_FILL: begin
        w_addr_nxt  = {1'b0, w_fill_nxt};
        w_wr0_nxt   = 1'b1;
        w_wr1_nxt   = 1'b1;
        w_wdata_nxt = BG_COLOR;
        w_perm_nxt  = 1'b1;
      end
      default: w_ready_nxt = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_op        <= 2'd0;
      r_size      <= 2'd0;
      r_x         <= 6'd0;
      r_y         <= 6'd0;
      r_color     <= 12'd0;
      r_dx        <= 2'd0;
      r_dy        <= 2'd0;
      r_fill      <= 11'd0;
      r_cur_x     <= 6'd0;
      r_cur_y     <= 6'd0;
      r_cur_size  <= 2'd0;
      r_cur_valid <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_addr      <= 12'd0;
      r_wr0       <= 1'b0;
      r_wr1       <= 1'b0;
      r_wdata     <= 12'd0;
      r_perm      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_size      <= w_size_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_color     <= w_color_nxt;
      r_dx        <= w_dx_nxt;
      r_dy        <= w_dy_nxt;
      r_fill      <= w_fill_nxt;
      r_cmd_ready <= w_ready_nxt;
      r_done      <= w_done_nxt;
      r_addr      <= w_addr_nxt;
      r_wr0       <= w_wr0_nxt;
      r_wr1       <= w_wr1_nxt;
      r_wdata     <= w_wdata_nxt;
      r_perm      <= w_perm_nxt;
      // The cursor record only changes once a MOVE has finished drawing.
      if (r_state == S_DRAW && w_state_nxt == S_IDLE && r_op == OP_MOVE) begin
        r_cur_x     <= r_x;
        r_cur_y     <= r_y;
        r_cur_size  <= r_size;
        r_cur_valid <= 1'b1;
      end else if (r_state == S_FILL && w_state_nxt == S_IDLE) begin
        r_cur_valid <= 1'b0;
      end
    end
  end

  assign o_cmd_ready       = r_cmd_ready;
  assign o_done            = r_done;
  assign o_addr_write      = r_addr;
  assign o_wr0             = r_wr0;
  assign o_wr1             = r_wr1;
  assign o_wdata           = r_wdata;
  assign o_paint_permanent = r_perm;

endmodule

// File: tb/tb_paint_brush_ctrl.sv
// tb_paint_brush_ctrl: directed checks of paint_brush_ctrl write sequences.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: commands are held valid until accepted.
module tb_paint_brush_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_x, cmd_y;
  logic [1:0]  cmd_size;
  logic [11:0] cmd_color;
  logic        done;
  logic [11:0] addr_write;
  logic        wr0, wr1;
  logic [11:0] wdata;
  logic        paint_permanent;
  logic [11:0] b_rdata0, b_rdata1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  paint_brush_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_x(cmd_x), .i_cmd_y(cmd_y), .i_cmd_size(cmd_size),
    .i_cmd_color(cmd_color), .o_done(done), .o_addr_write(addr_write),
    .o_wr0(wr0), .o_wr1(wr1), .o_wdata(wdata), .o_paint_permanent(paint_permanent),
    .i_b_rdata0(b_rdata0), .i_b_rdata1(b_rdata1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                       input logic [1:0] sz, input logic [11:0] col);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_size = sz; cmd_color = col;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_x = 6'd1; cmd_y = 6'd1;
    cmd_size = 2'd0; cmd_color = 12'hABC; b_rdata0 = 12'h0; b_rdata1 = 12'h0;
    step(); step();
    n_vec++;
    if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b10000, 12'd0, 12'd0}) begin
      n_err++; $display("FAIL reset_held got %h exp %h", {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b10000, 24'd0});
    end
    rst = 1'b0; cmd_valid = 1'b0;
    step();
    n_vec++;
    if ({cmd_ready, done, wr0, wr1} !== 4'b1000) begin
      n_err++; $display("FAIL reset_release got %b exp 1000", {cmd_ready, done, wr0, wr1});
    end
  endtask

  task automatic test_paint_bank0();
    logic [11:0] a [4];
    a = '{12'd197, 12'd198, 12'd261, 12'd262};
    issue(2'd1, 6'd5, 6'd3, 2'd1, 12'hF00);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b00101, a[i], 12'hF00}) begin
        n_err++; $display("FAIL paint0_px%0d got %h exp %h", i, {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b00101, a[i], 12'hF00});
      end
      step();
    end
    n_vec++;
    if ({cmd_ready, done, wr0, wr1} !== 4'b1100) begin
      n_err++; $display("FAIL paint0_done got %b exp 1100", {cmd_ready, done, wr0, wr1});
    end
    step();
    n_vec++;
    if ({cmd_ready, done} !== 2'b10) begin
      n_err++; $display("FAIL paint0_pulse got %b exp 10", {cmd_ready, done});
    end
  endtask

  task automatic test_paint_bank1();
    issue(2'd1, 6'd10, 6'd40, 2'd0, 12'h0F0);
    n_vec++;
    if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b00011, 12'd522, 12'h0F0}) begin
      n_err++; $display("FAIL paint1_px got %h exp %h", {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b00011, 12'd522, 12'h0F0});
    end
    step();
    n_vec++;
    if ({cmd_ready, done, wr0, wr1} !== 4'b1100) begin
      n_err++; $display("FAIL paint1_done got %b exp 1100", {cmd_ready, done, wr0, wr1});
    end
  endtask

  task automatic test_erase();
    issue(2'd2, 6'd5, 6'd3, 2'd0, 12'hFFF);
    n_vec++;
    if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b00101, 12'd197, 12'h000}) begin
      n_err++; $display("FAIL erase_px got %h exp %h", {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b00101, 12'd197, 12'h000});
    end
    step();
    n_vec++;
    if ({cmd_ready, done} !== 2'b11) begin
      n_err++; $display("FAIL erase_done got %b exp 11", {cmd_ready, done});
    end
  endtask

  task automatic test_move_pair();
    b_rdata0 = 12'h123; b_rdata1 = 12'hBAD;
    issue(2'd0, 6'd0, 6'd0, 2'd0, 12'hFFF);
    n_vec++;
    if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b00100, 12'd0, 12'hFFF}) begin
      n_err++; $display("FAIL move1_px got %h exp %h", {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b00100, 12'd0, 12'hFFF});
    end
    step();
    n_vec++;
    if ({cmd_ready, done} !== 2'b11) begin
      n_err++; $display("FAIL move1_done got %b exp 11", {cmd_ready, done});
    end
    issue(2'd0, 6'd1, 6'd0, 2'd0, 12'hFFF);
    n_vec++;
    if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write} !== {5'b00000, 12'd0}) begin
      n_err++; $display("FAIL move2_rd got %h exp %h", {cmd_ready, done, wr0, wr1, paint_permanent, addr_write}, {5'b00000, 12'd0});
    end
    step();
    n_vec++;
    if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b00100, 12'd0, 12'h123}) begin
      n_err++; $display("FAIL move2_wr got %h exp %h", {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b00100, 12'd0, 12'h123});
    end
    step();
    n_vec++;
    if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b00100, 12'd1, 12'hFFF}) begin
      n_err++; $display("FAIL move2_draw got %h exp %h", {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b00100, 12'd1, 12'hFFF});
    end
    step();
    n_vec++;
    if ({cmd_ready, done, wr0, wr1} !== 4'b1100) begin
      n_err++; $display("FAIL move2_done got %b exp 1100", {cmd_ready, done, wr0, wr1});
    end
  endtask

  task automatic test_clipping();
    issue(2'd1, 6'd63, 6'd63, 2'd3, 12'hABC);
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (i == 0) begin
        if ({done, wr0, wr1, paint_permanent, addr_write} !== {4'b0011, 12'd2047}) begin
          n_err++; $display("FAIL clip_px0 got %h exp %h", {done, wr0, wr1, paint_permanent, addr_write}, {4'b0011, 12'd2047});
        end
      end else if ({done, wr0, wr1, paint_permanent} !== 4'b0001) begin
        n_err++; $display("FAIL clip_px%0d got %b exp 0001", i, {done, wr0, wr1, paint_permanent});
      end
      step();
    end
    n_vec++;
    if ({cmd_ready, done, wr0, wr1} !== 4'b1100) begin
      n_err++; $display("FAIL clip_done got %b exp 1100", {cmd_ready, done, wr0, wr1});
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a [4];
    a = '{12'd130, 12'd131, 12'd194, 12'd195};
    issue(2'd1, 6'd2, 6'd2, 2'd1, 12'h111);
    // Next command held valid while the first is still busy.
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_x = 6'd10; cmd_y = 6'd2; cmd_size = 2'd0; cmd_color = 12'h222;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b00101, a[i], 12'h111}) begin
        n_err++; $display("FAIL b2b_first_px%0d got %h exp %h", i, {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b00101, a[i], 12'h111});
      end
      step();
    end
    n_vec++;
    if ({cmd_ready, done} !== 2'b11) begin
      n_err++; $display("FAIL b2b_first_done got %b exp 11", {cmd_ready, done});
    end
    step();
    cmd_valid = 1'b0;
    n_vec++;
    if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b00101, 12'd138, 12'h222}) begin
      n_err++; $display("FAIL b2b_second_px got %h exp %h", {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b00101, 12'd138, 12'h222});
    end
    step();
    n_vec++;
    if ({cmd_ready, done} !== 2'b11) begin
      n_err++; $display("FAIL b2b_second_done got %b exp 11", {cmd_ready, done});
    end
  endtask

  task automatic test_clear();
    issue(2'd3, 6'd7, 6'd7, 2'd2, 12'hFFF);
    for (int i = 0; i < 2048; i++) begin
      n_vec++;
      if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b00111, 12'(i), 12'h000}) begin
        n_err++; $display("FAIL clear_cyc%0d got %h exp %h", i, {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b00111, 12'(i), 12'h000});
      end
      step();
    end
    n_vec++;
    if ({cmd_ready, done, wr0, wr1} !== 4'b1100) begin
      n_err++; $display("FAIL clear_done got %b exp 1100", {cmd_ready, done, wr0, wr1});
    end
  endtask

  task automatic test_clear_reset();
    // Establish a cursor so reset has a valid record to drop.
    issue(2'd0, 6'd20, 6'd20, 2'd0, 12'h00F);
    step();
    issue(2'd3, 6'd0, 6'd0, 2'd0, 12'h000);
    for (int i = 0; i < 99; i++) step();
    n_vec++;
    if ({wr0, wr1, addr_write} !== {2'b11, 12'd99}) begin
      n_err++; $display("FAIL clrst_cyc100 got %h exp %h", {wr0, wr1, addr_write}, {2'b11, 12'd99});
    end
    rst = 1'b1;
    step();
    n_vec++;
    if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b10000, 24'd0}) begin
      n_err++; $display("FAIL clrst_reset got %h exp %h", {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b10000, 24'd0});
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if ({cmd_ready, done, wr0, wr1} !== 4'b1000) begin
        n_err++; $display("FAIL clrst_idle%0d got %b exp 1000", i, {cmd_ready, done, wr0, wr1});
      end
    end
    // Cursor record was dropped: this MOVE draws immediately, no restore.
    issue(2'd0, 6'd21, 6'd20, 2'd0, 12'h0F0);
    n_vec++;
    if ({cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata} !== {5'b00100, 12'd1301, 12'h0F0}) begin
      n_err++; $display("FAIL clrst_move got %h exp %h", {cmd_ready, done, wr0, wr1, paint_permanent, addr_write, wdata}, {5'b00100, 12'd1301, 12'h0F0});
    end
    step();
    n_vec++;
    if ({cmd_ready, done} !== 2'b11) begin
      n_err++; $display("FAIL clrst_move_done got %b exp 11", {cmd_ready, done});
    end
  endtask

  initial begin
    test_reset();
    test_paint_bank0();
    test_paint_bank1();
    test_erase();
    test_move_pair();
    test_clipping();
    test_back_to_back();
    test_clear();
    test_clear_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
